// File: rtl/vmask_cmp_packer.sv
// -----------------------------------------------------------------------------
// vmask_cmp_packer
//
// Purpose:
//   Takes per-beat packed equal / less-than element flags from the vALU compare
//   selector and applies the vector-compare opcode (vmseq/vmsne/vmslt/vmsle/
//   vmsgt/vmsge). It then packs one result bit per element into REQ_DATA_WIDTH-
//   bit mask words for mask write-back. One output word is buffered, and a
//   valid/ready handshake applies backpressure upstream.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous discard of the partial word and the output buffer
//   in_valid     upstream beat valid
//   in_ready     upstream beat accepted when in_valid & in_ready
//   in_last      last beat of the instruction; flushes the partial word
//   in_sew       element width code (0=8b, 1=16b, 2=32b, 3=64b)
//   in_cmp_op    0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6/7 force result to 0
//   in_equal     per-element equal flags; only the low n bits are meaningful
//   in_lt        per-element less-than flags; only the low n bits are meaningful
//   out_valid    mask word available
//   out_ready    consumer accepts the word when out_valid & out_ready
//   out_mask     packed mask; element k of the word is in bit k
//   out_last     the word closes an instruction
// -----------------------------------------------------------------------------
module vmask_cmp_packer #(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int SEW_WIDTH      = 2,
    parameter int REQ_BE_WIDTH   = REQ_DATA_WIDTH / 8,
    parameter int ENABLE_64_BIT  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [SEW_WIDTH-1:0]      in_sew,
    input  logic [2:0]                in_cmp_op,
    input  logic [REQ_BE_WIDTH-1:0]   in_equal,
    input  logic [REQ_BE_WIDTH-1:0]   in_lt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REQ_DATA_WIDTH-1:0] out_mask,
    output logic                      out_last
);

    localparam int PTR_W = $clog2(REQ_DATA_WIDTH) + 1;
    // One extra bit so ptr + n can never wrap, even when the element width
    // changes in the middle of a word and the sum overshoots the word size.
    localparam int SUM_W = PTR_W + 1;

    typedef enum logic [2:0] {
        OP_EQ = 3'd0,
        OP_NE = 3'd1,
        OP_LT = 3'd2,
        OP_LE = 3'd3,
        OP_GT = 3'd4,
        OP_GE = 3'd5
    } cmp_op_e;

    // State
    logic [REQ_DATA_WIDTH-1:0] acc_q, acc_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [REQ_DATA_WIDTH-1:0] out_mask_q, out_mask_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;

    // Datapath
    logic [SEW_WIDTH-1:0]      eff_sew;
    logic [31:0]               n_elems;
    logic [REQ_BE_WIDTH-1:0]   lane_mask;
    logic [REQ_BE_WIDTH-1:0]   r_raw;
    logic [REQ_BE_WIDTH-1:0]   r_bits;
    logic [REQ_DATA_WIDTH-1:0] nxt;
    logic [SUM_W-1:0]          ptr_sum;
    logic                      word_full;
    logic                      accept;
    logic                      complete;

    // The output buffer is a one-word skid: a new beat may enter in the same
    // cycle the buffered word drains.
    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        eff_sew   = in_sew;
        n_elems   = '0;
        lane_mask = '0;
        r_raw     = '0;
        r_bits    = '0;
        nxt       = '0;
        ptr_sum   = '0;
        word_full = 1'b0;
        complete  = 1'b0;

        // Without 64-bit support, sew=3 runs the 32-bit element layout.
        if ((ENABLE_64_BIT == 0) && (in_sew == SEW_WIDTH'(3))) begin
            eff_sew = SEW_WIDTH'(2);
        end
        n_elems = 32'(REQ_BE_WIDTH) >> eff_sew;

        for (int i = 0; i < REQ_BE_WIDTH; i++) begin
            lane_mask[i] = (32'(i) < n_elems);
        end

        case (cmp_op_e'(in_cmp_op))
            OP_EQ:   r_raw = in_equal;
            OP_NE:   r_raw = ~in_equal;
            OP_LT:   r_raw = in_lt;
            OP_LE:   r_raw = in_lt | in_equal;
            OP_GT:   r_raw = ~in_lt & ~in_equal;
            OP_GE:   r_raw = ~in_lt;
            default: r_raw = '0;
        endcase
        // Lanes beyond the element count carry garbage and must not reach acc.
        r_bits = r_raw & lane_mask;

        // acc is zero at and above ptr, so OR-ing in the shifted bits is enough.
        // Bits shifted past the top of the word are dropped, which keeps that
        // property intact even if sew changes mid-word.
        nxt       = acc_q | (REQ_DATA_WIDTH'(r_bits) << ptr_q);
        ptr_sum   = {1'b0, ptr_q} + SUM_W'(n_elems);
        word_full = (ptr_sum >= SUM_W'(REQ_DATA_WIDTH));
        complete  = accept & (word_full | in_last);
    end

    always_comb begin
        acc_d       = acc_q;
        ptr_d       = ptr_q;
        out_mask_d  = out_mask_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (clear) begin
            acc_d       = '0;
            ptr_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            // A completion in the drain cycle reloads the buffer and overrides
            // the clear of out_valid above.
            if (complete) begin
                out_mask_d  = nxt;
                out_last_d  = in_last;
                out_valid_d = 1'b1;
                acc_d       = '0;
                ptr_d       = '0;
            end else if (accept) begin
                acc_d = nxt;
                ptr_d = ptr_sum[PTR_W-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            ptr_q       <= '0;
            out_mask_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ptr_q       <= ptr_d;
            out_mask_q  <= out_mask_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mask  = out_mask_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_vmask_cmp_packer.sv
// -----------------------------------------------------------------------------
// tb_vmask_cmp_packer
//
// Purpose:
//   Self-checking bench for vmask_cmp_packer. Expected mask words are pushed to
//   a queue as beats are driven. A negedge monitor pops and compares them
//   whenever the DUT hands a word to the consumer. A second instance with
//   64-bit elements enabled covers the sew=3 mapping.
// -----------------------------------------------------------------------------
module tb_vmask_cmp_packer;

    localparam int DW  = 64;
    localparam int BEW = DW / 8;
    localparam int SW  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic            out_ready = 1'b1;
    logic [SW-1:0]   in_sew = '0;
    logic [2:0]      in_cmp_op = '0;
    logic [BEW-1:0]  in_equal = '0;
    logic [BEW-1:0]  in_lt = '0;

    logic            in_ready, out_valid, out_last;
    logic [DW-1:0]   out_mask;
    logic            in_ready_w, out_valid_w, out_last_w;
    logic [DW-1:0]   out_mask_w;

    typedef struct packed {
        logic [DW-1:0] mask;
        logic          last;
    } word_t;

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    vmask_cmp_packer #(.REQ_DATA_WIDTH(DW), .SEW_WIDTH(SW), .ENABLE_64_BIT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_sew(in_sew), .in_cmp_op(in_cmp_op), .in_equal(in_equal), .in_lt(in_lt),
        .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_last(out_last)
    );

    vmask_cmp_packer #(.REQ_DATA_WIDTH(DW), .SEW_WIDTH(SW), .ENABLE_64_BIT(1)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_last(in_last),
        .in_sew(in_sew), .in_cmp_op(in_cmp_op), .in_equal(in_equal), .in_lt(in_lt),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_mask(out_mask_w), .out_last(out_last_w)
    );

    // Scoreboard: every word handed to the consumer must match the oldest expectation.
    always @(negedge clk) begin
        word_t e;
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_word got mask=%h last=%b, expected no word", out_mask, out_last);
            end else begin
                e = exp_q.pop_front();
                if ({out_mask, out_last} !== e)
                    $display("FAIL word got mask=%h last=%b, expected mask=%h last=%b",
                             out_mask, out_last, e.mask, e.last);
                else
                    n_pass++;
            end
        end
    end

    // Drive one beat starting at posedge+1; returns at posedge+1 after acceptance.
    task automatic send_beat(input logic [SW-1:0] sew, input logic [2:0] op,
                             input logic [BEW-1:0] eq, input logic [BEW-1:0] lt,
                             input logic last);
        int k;
        in_sew    = sew;
        in_cmp_op = op;
        in_equal  = eq;
        in_lt     = lt;
        in_last   = last;
        in_valid  = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL beat_accept_timeout in_ready=%b after %0d cycles, expected 1", in_ready, k);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({out_valid, in_ready, out_last, out_mask} !== {1'b0, 1'b1, 1'b0, 64'h0})
            $display("FAIL reset_state got valid=%b ready=%b last=%b mask=%h, expected 0 1 0 0",
                     out_valid, in_ready, out_last, out_mask);
        else
            n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_eq_sew8();
        out_ready = 1'b1;
        exp_q.push_back('{mask: 64'hA5A5_A5A5_A5A5_A5A5, last: 1'b1});
        for (int i = 0; i < 8; i++) begin
            send_beat(2'd0, 3'd0, 8'hA5, 8'h00, i == 7);
            if (i == 6) begin
                n_checks++;
                if (out_valid !== 1'b0) $display("FAIL eq_early_valid got %b, expected 0", out_valid);
                else n_pass++;
            end
        end
        n_checks++;
        if ({out_valid, out_last} !== 2'b11)
            $display("FAIL eq_latency got valid=%b last=%b, expected 1 1", out_valid, out_last);
        else
            n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL eq_single_word got valid=%b, expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_lt_sew32();
        exp_q.push_back('{mask: 64'h39, last: 1'b1});
        send_beat(2'd2, 3'd2, 8'hFF, 8'hFD, 1'b0);
        send_beat(2'd2, 3'd2, 8'hFF, 8'hAE, 1'b0);
        send_beat(2'd2, 3'd2, 8'hFF, 8'h57, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_op_sweep();
        logic [3:0] exp_tbl [8];
        exp_tbl = '{4'h3, 4'hC, 4'h4, 4'h7, 4'h8, 4'hB, 4'h0, 4'h0};
        for (int op = 0; op < 8; op++) begin
            exp_q.push_back('{mask: DW'(exp_tbl[op]), last: 1'b1});
            send_beat(2'd1, 3'(op), 8'hF3, 8'hA4, 1'b1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] mask_bp;
        logic [7:0]    v;
        mask_bp   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 8'(i * 17 + 1);
            mask_bp[8*i +: 8] = v;
            send_beat(2'd0, 3'd0, v, 8'h00, 1'b0);
        end
        exp_q.push_back('{mask: mask_bp, last: 1'b0});
        n_checks++;
        if ({out_valid, in_ready} !== 2'b10)
            $display("FAIL bp_full got valid=%b ready=%b, expected 1 0", out_valid, in_ready);
        else
            n_pass++;
        // Ninth beat waits while the consumer stalls.
        in_sew = 2'd0; in_cmp_op = 3'd0; in_equal = 8'h3C; in_lt = 8'h00; in_last = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({in_ready, out_valid, out_mask} !== {1'b0, 1'b1, mask_bp})
                $display("FAIL bp_stall got ready=%b valid=%b mask=%h, expected 0 1 %h",
                         in_ready, out_valid, out_mask, mask_bp);
            else
                n_pass++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_release got ready=%b, expected 1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, u_dut.ptr_q} !== {1'b0, 7'd8})
            $display("FAIL bp_ptr got valid=%b ptr=%0d, expected 0 8", out_valid, u_dut.ptr_q);
        else
            n_pass++;
        exp_q.push_back('{mask: 64'h5A3C, last: 1'b1});
        send_beat(2'd0, 3'd0, 8'h5A, 8'h00, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) send_beat(2'd0, 3'd0, 8'hFF, 8'h00, 1'b0);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL mid_reset got valid=%b ready=%b, expected 0 1", out_valid, in_ready);
        else
            n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{mask: 64'h0101_0101_0101_0101, last: 1'b1});
        for (int i = 0; i < 8; i++) send_beat(2'd0, 3'd0, 8'h01, 8'h00, i == 7);

        for (int i = 0; i < 3; i++) send_beat(2'd0, 3'd0, 8'hFF, 8'h00, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_q.push_back('{mask: 64'h0101_0101_0101_0101, last: 1'b1});
        for (int i = 0; i < 8; i++) send_beat(2'd0, 3'd0, 8'h01, 8'h00, i == 7);
        @(posedge clk);
        #1;

        // Clear also drops a word waiting in the output buffer.
        out_ready = 1'b0;
        send_beat(2'd0, 3'd0, 8'h77, 8'h00, 1'b1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if ({out_valid, out_last} !== 2'b00)
            $display("FAIL clear_buffer got valid=%b last=%b, expected 0 0", out_valid, out_last);
        else
            n_pass++;
    endtask

    task automatic test_sew64();
        exp_q.push_back('{mask: 64'h3, last: 1'b1});
        send_beat(2'd3, 3'd0, 8'h03, 8'h00, 1'b1);
        n_checks++;
        if ({out_valid, out_mask} !== {1'b1, 64'h3})
            $display("FAIL sew64_off got valid=%b mask=%h, expected 1 3", out_valid, out_mask);
        else
            n_pass++;
        n_checks++;
        if ({out_valid_w, out_last_w, out_mask_w} !== {1'b1, 1'b1, 64'h1})
            $display("FAIL sew64_on got valid=%b last=%b mask=%h, expected 1 1 1",
                     out_valid_w, out_last_w, out_mask_w);
        else
            n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w0, w1;
        logic [7:0]    v;
        time           t0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 8'(i * 29 + 7);
            w0[8*i +: 8] = v;
            v = 8'((i + 8) * 29 + 7);
            w1[8*i +: 8] = v;
        end
        exp_q.push_back('{mask: w0, last: 1'b0});
        exp_q.push_back('{mask: w1, last: 1'b1});
        t0 = $time;
        for (int i = 0; i < 16; i++) send_beat(2'd0, 3'd0, 8'(i * 29 + 7), 8'h00, i == 15);
        n_checks++;
        if (($time - t0) !== 160)
            $display("FAIL b2b_throughput got %0t, expected 160", $time - t0);
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_eq_sew8();
        test_lt_sew32();
        test_op_sweep();
        test_backpressure();
        test_reset_mid();
        test_sew64();
        test_back_to_back();
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL words_missing got %0d pending, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
